ps2_tx: RTL
===========

PS2_TX -- requirements
Module: ps2_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYC, default 2500, clock-low inhibit time in clk cycles (100 us at 25 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 375000, frame watchdog in clk cycles (15 ms at 25 MHz).
REQ-003 SHALL have parameter FILT_LEN, default 4, consecutive equal samples required to accept a line level change.
REQ-004 SHALL have port clk  in  1  system clock, 25 MHz, all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port tx_data  in  8  command byte to send to the keyboard.
REQ-007 SHALL have port tx_valid  in  1  request; accepted when tx_valid and tx_ready are both 1 in the same cycle.
REQ-008 SHALL have port tx_ready  out  1  1 only in IDLE.
REQ-009 SHALL have port done  out  1  one-cycle pulse when the frame is acknowledged and both lines are back high.
REQ-010 SHALL have port err  out  1  one-cycle pulse on missing ACK or watchdog expiry.
REQ-011 SHALL have port rx_inhibit  out  1  1 whenever not IDLE; the receive path discards bytes while it is 1.
REQ-012 SHALL have ports ps2_c_in / ps2_d_in  in  1  raw pad levels of PS/2 clock and data.
REQ-013 SHALL have ports ps2_c_oe / ps2_d_oe  out  1  1 = pull line low (open-drain), 0 = release.

Function
REQ-014 SHALL pass each raw line through a 2-FF synchronizer and a FILT_LEN glitch filter; filtered value resets to 1.
REQ-015 SHALL detect a falling edge as filtered clock previous 1, current 0; edge is usable in the cycle after detection.
REQ-016 SHALL implement states IDLE, INHIBIT, START, BITS, PARITY, STOP, ACK, WAIT_IDLE.
REQ-017 IDLE: both oe 0; on accept latch tx_data into shift register, compute odd parity (parity = ~^tx_data), clear counters, go INHIBIT.
REQ-018 INHIBIT: ps2_c_oe 1 for exactly INHIBIT_CYC cycles; in the last cycle set ps2_d_oe 1; go START.
REQ-019 START: ps2_c_oe 0, ps2_d_oe 1 (start bit 0); watchdog starts counting; on falling edge 1 drive bit 0, go BITS.
REQ-020 BITS: ps2_d_oe = ~data bit, LSB first; falling edges 2..8 advance to bits 1..7; bit counter 3 bits; falling edge 9 go PARITY.
REQ-021 PARITY: ps2_d_oe = ~parity; falling edge 10 releases data (stop bit 1), go STOP.
REQ-022 STOP: ps2_d_oe 0; falling edge 11 samples filtered data: 0 -> WAIT_IDLE, 1 -> err pulse, IDLE.
REQ-023 WAIT_IDLE: when filtered clock and data both 1, pulse done, go IDLE.
REQ-024 Watchdog: 19-bit counter from START entry; reaching TIMEOUT_CYC in any state START..WAIT_IDLE -> release both lines, err pulse, IDLE in the same transition.
REQ-025 done and err SHALL never be 1 in the same cycle.
REQ-026 tx_valid while tx_ready=0 SHALL be ignored with no buffering.
REQ-027 Data line changes SHALL occur only while filtered clock is low (after a falling edge), never on a rising edge.

Reset
REQ-028 While rst=0 at a clk edge: state IDLE, ps2_c_oe 0, ps2_d_oe 0, done 0, err 0, counters 0, filters 1; tx_ready=1 and rx_inhibit=0 in the first cycle after release.
REQ-029 Reset mid-frame SHALL release both lines at that clock edge; no done or err is emitted for the aborted frame.

Structure
REQ-030 State encoding, default INHIBIT_CYC / TIMEOUT_CYC values and PS/2 command constants (0xED set-LEDs, 0xFF reset) SHALL live in shared package ps2_pkg.
REQ-031 Synchronizer plus glitch filter SHALL be sub-module ps2_line_filter, instantiated once per line.
REQ-032 Target size 150-300 lines of RTL including the sub-module.

Verification
REQ-033 Send 0xED with device model ACK -> ps2_c_oe 1 for 2500 cycles; data bits 1,0,1,1,0,1,1,1; parity 1; one done pulse; err stays 0.
REQ-034 Send 0x01 -> parity bit 0 on the line; done pulse.
REQ-035 Device holds data high at edge 11 -> err pulse, no done, both oe 0, tx_ready 1 next cycle.
REQ-036 Device never clocks -> err exactly TIMEOUT_CYC cycles after START entry; lines released.
REQ-037 2-cycle low glitch on ps2_c during BITS -> no bit advance; frame completes correctly.
REQ-038 rst=0 at bit 4; tx_valid pulsed while busy -> lines released at the reset edge; busy request ignored; next request sent cleanly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmit path.
// Contents: host-to-device FSM state type, default timing constants
// (25 MHz clock) and the keyboard command bytes used by the system.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_START,
    ST_BITS,
    ST_PARITY,
    ST_STOP,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_state_t;

  // 100 us clock inhibit and 15 ms frame watchdog at 25 MHz
  localparam int unsigned PS2_INHIBIT_CYC_DEF = 2500;
  localparam int unsigned PS2_TIMEOUT_CYC_DEF = 375000;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

endpackage

// File: rtl/ps2_tx_if.sv
// Command handshake between the system and the PS/2 transmitter.
//   tx_data  : byte to send              (master -> slave)
//   tx_valid : request                   (master -> slave)
//   tx_ready : transmitter idle          (slave -> master)
//   done     : frame acknowledged pulse  (slave -> master)
//   err      : no ACK / watchdog pulse   (slave -> master)
interface ps2_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       done;
  logic       err;

  modport master (output tx_data, output tx_valid,
                  input  tx_ready, input done, input err);
  modport slave  (input  tx_data, input tx_valid,
                  output tx_ready, output done, output err);
endinterface

// File: rtl/ps2_line_filter.sv
// 2-FF synchronizer followed by a glitch filter for one PS/2 pad.
// The filtered level only follows the synchronized input after FILT_LEN
// consecutive samples disagree with it. Everything resets to 1 (idle line).
//   clk     : system clock
//   rst     : synchronous, active-low reset
//   i_raw   : raw pad level
//   o_filt  : synchronized, filtered level
module ps2_line_filter #(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_filt
);

  localparam int unsigned CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic          r_s1;
  logic          r_s2;
  logic          r_filt;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1   <= 1'b1;
      r_s2   <= 1'b1;
      r_filt <= 1'b1;
      r_cnt  <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (r_s2 == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILT_LEN - 1)) begin
        r_filt <= r_s2;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_filt = r_filt;

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device command transmitter.
// Inhibits the clock, issues the request-to-send, then shifts out start,
// 8 data bits (LSB first), odd parity and stop on device-generated falling
// clock edges, and checks the device ACK. A watchdog aborts stuck frames.
//   clk                 : 25 MHz system clock
//   rst                 : synchronous, active-low reset
//   tx                  : command handshake (tx_data/tx_valid/tx_ready/done/err)
//   rx_inhibit          : high whenever a frame is in progress
//   ps2_c_in / ps2_d_in : raw pad levels
//   ps2_c_oe / ps2_d_oe : 1 pulls the open-drain line low
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYC = PS2_INHIBIT_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC = PS2_TIMEOUT_CYC_DEF,
  parameter int unsigned FILT_LEN    = 4
) (
  input  logic      clk,
  input  logic      rst,
  ps2_tx_if.slave   tx,
  output logic      rx_inhibit,
  input  logic      ps2_c_in,
  input  logic      ps2_d_in,
  output logic      ps2_c_oe,
  output logic      ps2_d_oe
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYC + 1);

  ps2_state_t       r_state;
  ps2_state_t       w_state_nxt;
  logic             w_c_filt;
  logic             w_d_filt;
  logic             r_c_prev;
  logic             r_fall;
  logic [7:0]       r_data;
  logic             r_par;
  logic [2:0]       r_bitcnt;
  logic [INH_W-1:0] r_inh;
  logic [18:0]      r_wd;
  logic             r_done;
  logic             r_err;
  logic             w_done_nxt;
  logic             w_err_nxt;
  logic             w_accept;
  logic             w_active;
  logic             w_c_oe;
  logic             w_d_oe;

  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_filt_c (
    .clk    (clk),
    .rst    (rst),
    .i_raw  (ps2_c_in),
    .o_filt (w_c_filt)
  );

  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_filt_d (
    .clk    (clk),
    .rst    (rst),
    .i_raw  (ps2_d_in),
    .o_filt (w_d_filt)
  );

  // watchdog runs from START entry through WAIT_IDLE
  assign w_active = (r_state != ST_IDLE) && (r_state != ST_INHIBIT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_c_prev <= 1'b1;
      r_fall   <= 1'b0;
      r_data   <= '0;
      r_par    <= 1'b0;
      r_bitcnt <= '0;
      r_inh    <= '0;
      r_wd     <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_c_prev <= w_c_filt;
      // registered so the edge acts one cycle after detection
      r_fall   <= r_c_prev & ~w_c_filt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
      if (w_accept) begin
        r_data   <= tx.tx_data;
        r_par    <= ~^tx.tx_data;
        r_bitcnt <= '0;
      end else if ((r_state == ST_BITS) && r_fall && (r_bitcnt != 3'd7)) begin
        r_bitcnt <= r_bitcnt + 3'd1;
      end
      r_inh <= (r_state == ST_INHIBIT) ? r_inh + INH_W'(1) : '0;
      r_wd  <= w_active ? r_wd + 19'd1 : '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_accept    = 1'b0;
    w_c_oe      = 1'b0;
    w_d_oe      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (tx.tx_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        w_c_oe = 1'b1;
        if (r_inh == INH_W'(INHIBIT_CYC - 1)) begin
          w_d_oe      = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        w_d_oe = 1'b1;
        if (r_fall) w_state_nxt = ST_BITS;
      end
      ST_BITS: begin
        w_d_oe = ~r_data[r_bitcnt];
        if (r_fall && (r_bitcnt == 3'd7)) w_state_nxt = ST_PARITY;
      end
      ST_PARITY: begin
        w_d_oe = ~r_par;
        if (r_fall) w_state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (r_fall) w_state_nxt = ST_ACK;
      end
      // ACK judges the filtered data level latched just after edge 11
      ST_ACK: begin
        if (w_d_filt) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (w_c_filt && w_d_filt) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // watchdog overrides everything, so done and err stay exclusive
    if (w_active && (r_wd == 19'(TIMEOUT_CYC - 1))) begin
      w_state_nxt = ST_IDLE;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b1;
    end
  end

  assign tx.tx_ready = (r_state == ST_IDLE);
  assign tx.done     = r_done;
  assign tx.err      = r_err;
  assign rx_inhibit  = (r_state != ST_IDLE);
  assign ps2_c_oe    = w_c_oe;
  assign ps2_d_oe    = w_d_oe;

endmodule
